feature_map_streamer: RTL and testbench

- Sits between a convolutional layer's output and the next layer's input.
- Captures the sparse, valid-qualified result stream (gaps from stride and border) into an internal feature-map store of OUT_SIZE*OUT_SIZE words.
- Replays that store as a dense raster pixel stream with a per-pixel clock-enable strobe, then appends zero pixels so the downstream pixel buffers can drain.
- Acts as the transmitter end of the pixel-stream interface the layers consume.

---
 rtl/feature_stream_pkg.sv | 17 +
 rtl/feature_map_ram.sv | 25 ++
 rtl/feature_map_streamer.sv | 152 +++++++++++++++
 tb/tb_feature_map_streamer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/feature_stream_pkg.sv
// Shared types and helpers for the feature-map streamer.
package feature_stream_pkg;

    // Frame lifecycle: capture the sparse stream, replay it densely, pad with zeros, pulse done
    typedef enum logic [1:0] {
        FILL   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2,
        DONE   = 2'd3
    } stream_state_t;

    // Width of one pixel word, all channel lanes packed side by side
    function automatic int pixel_width(input int d_width, input int channels);
        return d_width * channels;
    endfunction

endpackage

// File: rtl/feature_map_ram.sv
// Feature-map store: one write port, one registered read port, no reset on the array.
module feature_map_ram #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Synchronous write plus registered read so the array maps onto block RAM
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/feature_map_streamer.sv
// Captures a valid-qualified conv-layer result stream, then replays it as a dense
// strobed raster followed by optional zero padding for downstream buffers to drain.

`ifndef LOG2
`define LOG2(x) (((x) <= 1) ? 0 : $clog2(x))
`endif

module feature_map_streamer
    import feature_stream_pkg::*;
#(
    parameter int D_WIDTH      = 8,
    parameter int CHANNELS     = 1,
    parameter int OUT_SIZE     = 4,
    parameter int FLUSH_PIXELS = 0
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [pixel_width(D_WIDTH, CHANNELS)-1:0] in_data,
    input  logic                                      in_valid,
    input  logic                                      out_ready,
    output logic [pixel_width(D_WIDTH, CHANNELS)-1:0] out_data,
    output logic                                      out_en,
    output logic                                      frame_done,
    output logic                                      overflow
);

    localparam int PIX_W      = pixel_width(D_WIDTH, CHANNELS);
    localparam int N          = OUT_SIZE * OUT_SIZE;
    localparam int PTR_W      = `LOG2(N);
    localparam int CNT_RAW    = `LOG2(FLUSH_PIXELS + 1);
    localparam int CNT_W      = (CNT_RAW < 1) ? 1 : CNT_RAW;
    localparam int FLUSH_LAST = (FLUSH_PIXELS > 0) ? FLUSH_PIXELS - 1 : 0;

    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(N - 1);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(FLUSH_LAST);

    stream_state_t    state, state_next;
    logic [PTR_W-1:0] wr_ptr, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr, rd_ptr_next;
    logic [CNT_W-1:0] flush_cnt, flush_cnt_next;
    logic [PIX_W-1:0] out_data_next;
    logic             out_en_next;
    logic             frame_done_next;
    logic             overflow_next;
    logic             store_we;
    logic [PIX_W-1:0] store_q;

    // The store is addressed with the next read pointer, so its registered output
    // already holds store[rd_ptr] whenever a ready cycle wants to launch that pixel.
    feature_map_ram #(
        .WIDTH  (PIX_W),
        .DEPTH  (N),
        .ADDR_W (PTR_W)
    ) u_store (
        .clk     (clk),
        .we      (store_we),
        .wr_addr (wr_ptr),
        .wr_data (in_data),
        .rd_addr (rd_ptr_next),
        .rd_data (store_q)
    );

    // State, pointers and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FILL;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            flush_cnt  <= '0;
            out_data   <= '0;
            out_en     <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_next;
            wr_ptr     <= wr_ptr_next;
            rd_ptr     <= rd_ptr_next;
            flush_cnt  <= flush_cnt_next;
            out_data   <= out_data_next;
            out_en     <= out_en_next;
            frame_done <= frame_done_next;
            overflow   <= overflow_next;
        end
    end

    // Next-state and datapath decisions; the strobe defaults low so any stall idles it
    always_comb begin
        state_next      = state;
        wr_ptr_next     = wr_ptr;
        rd_ptr_next     = rd_ptr;
        flush_cnt_next  = flush_cnt;
        out_data_next   = out_data;
        out_en_next     = 1'b0;
        frame_done_next = 1'b0;
        overflow_next   = overflow;
        store_we        = 1'b0;

        case (state)
            FILL: begin
                if (in_valid) begin
                    store_we = 1'b1;
                    if (wr_ptr == LAST_PTR) begin
                        wr_ptr_next = '0;
                        state_next  = STREAM;
                    end else begin
                        wr_ptr_next = wr_ptr + PTR_W'(1);
                    end
                end
            end
            STREAM: begin
                if (out_ready) begin
                    out_data_next = store_q;
                    out_en_next   = 1'b1;
                    if (rd_ptr == LAST_PTR) begin
                        rd_ptr_next = '0;
                        if (FLUSH_PIXELS == 0) begin
                            state_next = DONE;
                        end else begin
                            state_next = FLUSH;
                        end
                    end else begin
                        rd_ptr_next = rd_ptr + PTR_W'(1);
                    end
                end
            end
            FLUSH: begin
                if (out_ready) begin
                    out_data_next = '0;
                    out_en_next   = 1'b1;
                    if (flush_cnt == LAST_CNT) begin
                        flush_cnt_next = '0;
                        state_next     = DONE;
                    end else begin
                        flush_cnt_next = flush_cnt + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                frame_done_next = 1'b1;
                state_next      = FILL;
            end
            default: begin
                state_next = FILL;
            end
        endcase

        if (in_valid && (state != FILL)) begin
            overflow_next = 1'b1;
        end
    end

endmodule

// File: tb/tb_feature_map_streamer.sv
// Directed bench: three streamer configurations driven with hand-computed frames.
module tb_feature_map_streamer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Configuration A: 8-bit, 1 channel, no flush
    logic        rst_a, valid_a, ready_a, en_a, done_a, ovf_a;
    logic [7:0]  in_a, out_a;
    // Configuration B: 8-bit, 1 channel, 5 flush pixels
    logic        rst_b, valid_b, ready_b, en_b, done_b, ovf_b;
    logic [7:0]  in_b, out_b;
    // Configuration C: 8-bit, 3 channels, no flush
    logic        rst_c, valid_c, ready_c, en_c, done_c, ovf_c;
    logic [23:0] in_c, out_c;

    feature_map_streamer #(.D_WIDTH(8), .CHANNELS(1), .OUT_SIZE(4), .FLUSH_PIXELS(0)) dut_a (
        .clk(clk), .rst_n(rst_a), .in_data(in_a), .in_valid(valid_a), .out_ready(ready_a),
        .out_data(out_a), .out_en(en_a), .frame_done(done_a), .overflow(ovf_a));

    feature_map_streamer #(.D_WIDTH(8), .CHANNELS(1), .OUT_SIZE(4), .FLUSH_PIXELS(5)) dut_b (
        .clk(clk), .rst_n(rst_b), .in_data(in_b), .in_valid(valid_b), .out_ready(ready_b),
        .out_data(out_b), .out_en(en_b), .frame_done(done_b), .overflow(ovf_b));

    feature_map_streamer #(.D_WIDTH(8), .CHANNELS(3), .OUT_SIZE(4), .FLUSH_PIXELS(0)) dut_c (
        .clk(clk), .rst_n(rst_c), .in_data(in_c), .in_valid(valid_c), .out_ready(ready_c),
        .out_data(out_c), .out_en(en_c), .frame_done(done_c), .overflow(ovf_c));

    int check_cnt = 0;
    int pass_cnt  = 0;
    int cyc       = 0;
    int done_a_cnt = 0, done_b_cnt = 0, done_c_cnt = 0;
    int first_a = 0, last_a = 0, last_b = 0, done_b_cyc = 0, norq_a = 0;
    logic rq_a = 1'b0;
    logic toggle_a = 1'b0;
    logic [31:0] cap_a[$];
    logic [31:0] cap_b[$];
    logic [31:0] cap_c[$];

    // Ready as the DUT saw it at the last rising edge
    always @(posedge clk) rq_a <= ready_a;

    // Alternating backpressure for configuration A
    always @(negedge clk) if (toggle_a) ready_a = ~ready_a;

    // Capture every strobed pixel and every done pulse
    always @(negedge clk) begin
        cyc++;
        if (en_a) begin
            if (cap_a.size() == 0) first_a = cyc;
            last_a = cyc;
            cap_a.push_back(32'(out_a));
            if (!rq_a) norq_a++;
        end
        if (done_a) done_a_cnt++;
        if (en_b) begin
            last_b = cyc;
            cap_b.push_back(32'(out_b));
        end
        if (done_b) begin
            done_b_cnt++;
            done_b_cyc = cyc;
        end
        if (en_c) cap_c.push_back(32'(out_c));
        if (done_c) done_c_cnt++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_cnt++;
        if (actual === expected) pass_cnt++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    function automatic logic [31:0] capAt(input int sel, input int idx);
        case (sel)
            0:       return (idx < cap_a.size()) ? cap_a[idx] : 32'hDEAD_BEEF;
            1:       return (idx < cap_b.size()) ? cap_b[idx] : 32'hDEAD_BEEF;
            default: return (idx < cap_c.size()) ? cap_c[idx] : 32'hDEAD_BEEF;
        endcase
    endfunction

    // Sixteen valid pulses, one every gap+1 cycles, pixel k = base + k
    task automatic applyStimulus(input int sel, input int base, input int gap);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            case (sel)
                0: begin valid_a = 1'b1; in_a = 8'(base + k); end
                1: begin valid_b = 1'b1; in_b = 8'(base + k); end
                default: begin
                    valid_c = 1'b1;
                    in_c = {8'(8'h30 + k), 8'(8'h20 + k), 8'(8'h10 + k)};
                end
            endcase
            @(negedge clk);
            valid_a = 1'b0;
            valid_b = 1'b0;
            valid_c = 1'b0;
            repeat (gap - 1) @(negedge clk);
        end
    endtask

    task automatic waitDone(input int sel, input int target, input int budget, input string tag);
        int cnt;
        cnt = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            cnt = (sel == 0) ? done_a_cnt : (sel == 1) ? done_b_cnt : done_c_cnt;
            if (cnt >= target) break;
        end
        checkOutput({tag, "_done_reached"}, 32'(cnt), 32'(target));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
        ready_a = 1'b0; ready_b = 1'b0; ready_c = 1'b0;
        in_a = '0; in_b = '0; in_c = '0;
        #12;
        checkOutput("rst_out_en", 32'(en_a), 32'd0);
        checkOutput("rst_out_data", 32'(out_a), 32'd0);
        checkOutput("rst_frame_done", 32'(done_a), 32'd0);
        checkOutput("rst_overflow", 32'(ovf_a), 32'd0);
        @(negedge clk);
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;

        // Sparse input, continuous ready: 16 consecutive strobes 0..15
        ready_a = 1'b1;
        applyStimulus(0, 0, 3);
        waitDone(0, 1, 80, "t1");
        repeat (4) @(negedge clk);
        #1;
        checkOutput("t1_done_once", 32'(done_a_cnt), 32'd1);
        checkOutput("t1_count", 32'(cap_a.size()), 32'd16);
        for (int k = 0; k < 16; k++) checkOutput("t1_pixel", capAt(0, k), 32'(k));
        checkOutput("t1_back_to_back", 32'(last_a - first_a), 32'd15);
        checkOutput("t1_overflow", 32'(ovf_a), 32'd0);

        // Alternating ready: same ordering, strobes only after ready
        cap_a.delete();
        norq_a = 0;
        toggle_a = 1'b1;
        applyStimulus(0, 8'h40, 1);
        waitDone(0, 2, 120, "t2");
        toggle_a = 1'b0;
        checkOutput("t2_count", 32'(cap_a.size()), 32'd16);
        for (int k = 0; k < 16; k++) checkOutput("t2_pixel", capAt(0, k), 32'(8'h40 + k));
        checkOutput("t2_strobe_without_ready", 32'(norq_a), 32'd0);

        // Dropped input during STREAM sets sticky overflow, frame unchanged
        cap_a.delete();
        ready_a = 1'b0;
        applyStimulus(0, 8'h50, 1);
        checkOutput("t4_ovf_before", 32'(ovf_a), 32'd0);
        @(negedge clk);
        valid_a = 1'b1;
        in_a = 8'hAA;
        @(negedge clk);
        valid_a = 1'b0;
        #1;
        checkOutput("t4_ovf_set", 32'(ovf_a), 32'd1);
        @(negedge clk);
        ready_a = 1'b1;
        waitDone(0, 3, 60, "t4");
        checkOutput("t4_count", 32'(cap_a.size()), 32'd16);
        for (int k = 0; k < 16; k++) checkOutput("t4_pixel", capAt(0, k), 32'(8'h50 + k));
        checkOutput("t4_ovf_sticky", 32'(ovf_a), 32'd1);
        cap_a.delete();
        applyStimulus(0, 8'h60, 1);
        waitDone(0, 4, 60, "t4b");
        checkOutput("t4b_count", 32'(cap_a.size()), 32'd16);
        checkOutput("t4b_first", capAt(0, 0), 32'h60);
        checkOutput("t4b_last", capAt(0, 15), 32'h6F);
        checkOutput("t4b_ovf_sticky", 32'(ovf_a), 32'd1);

        // Reset after seven streamed pixels, then a fresh frame 100..115
        cap_a.delete();
        applyStimulus(0, 8'h70, 1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (cap_a.size() >= 7) break;
        end
        checkOutput("t5_seen_seven", 32'(cap_a.size()), 32'd7);
        checkOutput("t5_pre_en", 32'(en_a), 32'd1);
        rst_a = 1'b0;
        #1;
        checkOutput("t5_rst_en", 32'(en_a), 32'd0);
        checkOutput("t5_rst_data", 32'(out_a), 32'd0);
        checkOutput("t5_rst_ovf", 32'(ovf_a), 32'd0);
        @(negedge clk);
        rst_a = 1'b1;
        cap_a.delete();
        applyStimulus(0, 100, 1);
        waitDone(0, 5, 60, "t5");
        checkOutput("t5_count", 32'(cap_a.size()), 32'd16);
        for (int k = 0; k < 16; k++) checkOutput("t5_pixel", capAt(0, k), 32'(100 + k));

        // Five zero flush pixels follow the frame, then done
        ready_b = 1'b1;
        applyStimulus(1, 0, 1);
        waitDone(1, 1, 60, "tb");
        checkOutput("flush_total_strobes", 32'(cap_b.size()), 32'd21);
        for (int k = 0; k < 21; k++) checkOutput("flush_pixel", capAt(1, k), (k < 16) ? 32'(k) : 32'd0);
        checkOutput("flush_done_after_last", 32'(done_b_cyc - last_b), 32'd1);
        checkOutput("flush_overflow", 32'(ovf_b), 32'd0);

        // Three channel lanes replay bit-exact
        ready_c = 1'b1;
        applyStimulus(2, 0, 1);
        waitDone(2, 1, 60, "tc");
        checkOutput("ch3_count", 32'(cap_c.size()), 32'd16);
        for (int k = 0; k < 16; k++) begin
            logic [31:0] w;
            w = capAt(2, k);
            checkOutput("ch3_lane0", 32'(w[7:0]),   32'(8'h10 + k));
            checkOutput("ch3_lane1", 32'(w[15:8]),  32'(8'h20 + k));
            checkOutput("ch3_lane2", 32'(w[23:16]), 32'(8'h30 + k));
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
